seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 100000, clk cycles per digit slot (1 kHz/digit at 100 MHz).
REQ-002 SHALL have parameter BLANK_CYC, default 1000, all-anodes-off cycles at the start of each slot; legal range 0..CLK_DIV-1.
REQ-003 SHALL have one clock; reset is synchronous and active-high: clk input 1, rising-edge system clock.
REQ-004 SHALL have rst input 1, synchronous active-high reset.
REQ-005 SHALL have en input 1: 1 = scan, 0 = display dark and scan halted.
REQ-006 SHALL have load input 1, single-cycle request to capture data_in, dp_in and blank_in.
REQ-007 SHALL have data_in input 16, four hex nibbles; nibble k drives digit k.
REQ-008 SHALL have dp_in input 4, per-digit decimal point, 1 = lit.
REQ-009 SHALL have blank_in input 4, per-digit blank, 1 = digit dark.
REQ-010 SHALL have ack output 1, one-cycle pulse when captured data becomes displayed.
REQ-011 SHALL have an output 4, active-low anodes, one-hot-low.
REQ-012 SHALL have seg output 7, active-low cathodes, bit order gfedcba.
REQ-013 SHALL have dp output 1, active-low decimal point.

Function
REQ-014 SHALL count prescaler cnt 0..CLK_DIV-1 while en=1; tick = (cnt==CLK_DIV-1); on tick cnt->0 and digit index idx->idx+1 mod 4 (3 wraps to 0).
REQ-015 SHALL treat a tick with idx==3 as the frame boundary.
REQ-016 SHALL on load=1 copy inputs to a shadow register and set pending; a load while pending overwrites the shadow, with a single ack produced.
REQ-017 SHALL with en=1 transfer shadow to the active register at the frame boundary, clear pending, and assert ack in the next cycle.
REQ-018 SHALL with en=0 transfer a pending shadow on the next edge and assert ack the cycle after.
REQ-019 SHALL when load coincides with a transfer edge, let the new load win: shadow takes the new data, pending stays 1, and the old shadow is transferred and acked.
REQ-020 SHALL register an/seg/dp: next an = 4'b1111 when en=0, cnt<BLANK_CYC or blank for idx; otherwise bit idx low, others high.
REQ-021 SHALL produce seg as the active-low hex pattern of active nibble idx (0->1000000, 4->0011001, A->0001000, F->0001110), and all ones when an is all high.
REQ-022 SHALL drive dp = ~dp bit idx, and 1 when an is all high.
REQ-023 SHALL with en=0 hold cnt=0 and idx=0, so scanning resumes at digit 0 with a blank interval.
REQ-024 SHALL produce an active-low anode pattern via a 2-to-4 decoder enabled by ~blanking.

Reset
REQ-025 SHALL on rst=1 force an=1111, seg=1111111, dp=1, ack=0, cnt=0, idx=0, pending=0, shadow=0, active=0.
REQ-026 SHALL drop pending data and give no ack when rst is asserted mid-frame or while pending; rst has priority over load.

Structure
REQ-027 SHALL place the 16-entry hex-to-segment table, segment bit-order constants and the all-off patterns in shared package seg_pkg.
REQ-028 SHALL instantiate the existing dec2to4 for anode select; no other sub-module.

Verification (CLK_DIV=4, BLANK_CYC=1)
REQ-029 SHALL check: rst held 2 cycles -> an=1111, seg=1111111, dp=1, ack=0.
REQ-030 SHALL check: en=0, load data_in=16'h1234 -> ack exactly 2 edges after load, then an=1111.
REQ-031 SHALL check: en=1 after REQ-030 -> each 4-cycle slot shows 1 blank cycle then an=1110 seg=0011001, 1101 seg=0110000, 1011 seg=0100100, 0111 seg=1111001, repeating.
REQ-032 SHALL check: en=1, load 16'hABCD mid-frame then 16'h00F0 two cycles later -> one ack after frame boundary; digit1 shows F (0001110), others 0.
REQ-033 SHALL check: blank_in=4'b0100, dp_in=4'b0001 -> slot 2 an=1111 all slot; dp=0 only in slot 0.
REQ-034 SHALL check: rst pulsed while pending -> no ack follows; outputs equal REQ-025 values.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment vectors are active-low, bit order gfedcba.
package seg_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    localparam logic [6:0] HEX_TBL [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  blank;
    } disp_t;

endpackage

// File: rtl/dec2to4.sv
// Active-low 2-to-4 decoder; all outputs high when disabled.
module dec2to4 (
    input  logic       en,
    input  logic [1:0] sel,
    output logic [3:0] y
);

    always_comb begin
        y = 4'b1111;
        if (en)
            y[sel] = 1'b0;
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with
// frame-synchronous double-buffered display data.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int CLK_DIV   = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    output logic        ack,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic          tick;
    logic          frame;
    logic          xfer;
    logic          pending;
    logic          in_blank;
    logic          blanking;
    logic [3:0]    nib;
    logic [3:0]    an_nxt;
    disp_t         cap;
    disp_t         shadow;
    disp_t         active;

    assign cap   = '{data: data_in, dp: dp_in, blank: blank_in};
    assign tick  = en && (cnt == LAST);
    assign frame = tick && (idx == 2'd3);
    // Halted display has no frame to wait for, so move data at once.
    assign xfer  = pending && (frame || !en);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (!en) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (tick) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // A load on a transfer edge keeps pending set for the new data.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
            ack     <= 1'b0;
        end else begin
            ack     <= xfer;
            pending <= load || (pending && !xfer);
            if (xfer)
                active <= shadow;
            if (load)
                shadow <= cap;
        end
    end

    generate
        if (BLANK_CYC > 0) begin : g_blank
            localparam logic [CW-1:0] BL = CW'(BLANK_CYC);
            assign in_blank = (cnt < BL);
        end else begin : g_noblank
            assign in_blank = 1'b0;
        end
    endgenerate

    assign blanking = !en || in_blank || active.blank[idx];
    assign nib      = active.data[{idx, 2'b00} +: 4];

    dec2to4 u_dec (
        .en  (!blanking),
        .sel (idx),
        .y   (an_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= an_nxt;
            seg <= blanking ? SEG_OFF : HEX_TBL[nib];
            dp  <= blanking ? 1'b1 : !active.dp[idx];
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with CLK_DIV=4, BLANK_CYC=1.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        ack;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.CLK_DIV(4), .BLANK_CYC(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .data_in  (data_in),
        .dp_in    (dp_in),
        .blank_in (blank_in),
        .ack      (ack),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    logic [6:0] hexs [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct {
        logic       en;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ack;
    } vec_t;

    vec_t tbl [16];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, ".an"}, 32'(an), 32'hF);
        chk({nm, ".seg"}, 32'(seg), 32'h7F);
        chk({nm, ".dp"}, 32'(dp), 32'h1);
        chk({nm, ".ack"}, 32'(ack), 32'h0);
    endtask

    // Expected {an, seg, dp} at cycle pos (0..15) of a frame.
    function automatic logic [11:0] model(input logic [15:0] d,
                                          input logic [3:0] p,
                                          input logic [3:0] b,
                                          input int pos);
        int s;
        logic [3:0] a;
        logic [3:0] nb;
        s = pos / 4;
        nb = d[s*4 +: 4];
        if ((pos % 4) == 0 || b[s])
            return {4'hF, 7'h7F, 1'b1};
        a = 4'hF;
        a[s] = 1'b0;
        return {a, hexs[nb], ~p[s]};
    endfunction

    task automatic run_frame(input string nm, input logic [15:0] d,
                             input logic [3:0] p, input logic [3:0] b);
        logic [11:0] e;
        for (int k = 0; k < 16; k++) begin
            cyc();
            e = model(d, p, b, k);
            chk({nm, ".an"}, 32'(an), 32'(e[11:8]));
            chk({nm, ".seg"}, 32'(seg), 32'(e[7:1]));
            chk({nm, ".dp"}, 32'(dp), 32'(e[0]));
            chk({nm, ".ack"}, 32'(ack), 32'h0);
        end
    endtask

    // One frame after a load at its first edge; optional second load.
    task automatic frame_ack(input string nm, input int k2,
                             input logic [15:0] d2);
        for (int k = 1; k <= 16; k++) begin
            cyc();
            load = (k == k2);
            if (k == k2)
                data_in = d2;
            chk({nm, ".ack"}, 32'(ack), 32'(k == 16));
        end
    endtask

    initial begin
        for (int s = 0; s < 4; s++) begin
            tbl[s*4] = '{1'b1, 4'hF, 7'h7F, 1'b1, 1'b0};
        end
        for (int k = 1; k < 4; k++) begin
            tbl[k]    = '{1'b1, 4'b1110, 7'b0011001, 1'b1, 1'b0};
            tbl[4+k]  = '{1'b1, 4'b1101, 7'b0110000, 1'b1, 1'b0};
            tbl[8+k]  = '{1'b1, 4'b1011, 7'b0100100, 1'b1, 1'b0};
            tbl[12+k] = '{1'b1, 4'b0111, 7'b1111001, 1'b1, 1'b0};
        end

        rst = 1'b1;
        en = 1'b0;
        load = 1'b0;
        data_in = '0;
        dp_in = '0;
        blank_in = '0;
        cyc();
        cyc();
        chk_idle("reset");
        rst = 1'b0;

        load = 1'b1;
        data_in = 16'h1234;
        cyc();
        load = 1'b0;
        chk("halt_ack_e1", 32'(ack), 32'h0);
        cyc();
        chk("halt_ack_e2", 32'(ack), 32'h1);
        cyc();
        chk("halt_ack_e3", 32'(ack), 32'h0);
        chk("halt_an", 32'(an), 32'hF);

        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 16; i++) begin
                en = tbl[i].en;
                cyc();
                chk("scan.an", 32'(an), 32'(tbl[i].an));
                chk("scan.seg", 32'(seg), 32'(tbl[i].seg));
                chk("scan.dp", 32'(dp), 32'(tbl[i].dp));
                chk("scan.ack", 32'(ack), 32'(tbl[i].ack));
            end
        end

        load = 1'b1;
        data_in = 16'hABCD;
        frame_ack("dbl_load", 2, 16'h00F0);
        run_frame("dbl_show", 16'h00F0, 4'h0, 4'h0);

        load = 1'b1;
        data_in = 16'h89AB;
        dp_in = 4'b0001;
        blank_in = 4'b0100;
        frame_ack("blank_load", 0, 16'h0);
        run_frame("blank_show", 16'h89AB, 4'b0001, 4'b0100);

        en = 1'b0;
        dp_in = '0;
        blank_in = '0;
        cyc();
        chk("off_an", 32'(an), 32'hF);
        load = 1'b1;
        data_in = 16'h1111;
        cyc();
        chk("coin_ack0", 32'(ack), 32'h0);
        data_in = 16'hC0DE;
        cyc();
        load = 1'b0;
        chk("coin_ack1", 32'(ack), 32'h1);
        cyc();
        chk("coin_ack2", 32'(ack), 32'h1);
        cyc();
        chk("coin_ack3", 32'(ack), 32'h0);
        en = 1'b1;
        run_frame("coin_show", 16'hC0DE, 4'h0, 4'h0);

        load = 1'b1;
        data_in = 16'hFFFF;
        cyc();
        load = 1'b0;
        cyc();
        cyc();
        cyc();
        rst = 1'b1;
        load = 1'b1;
        data_in = 16'hEEEE;
        cyc();
        rst = 1'b0;
        load = 1'b0;
        chk_idle("rst_pend");
        run_frame("rst_clear", 16'h0000, 4'h0, 4'h0);
        cyc();
        chk("rst_noack", 32'(ack), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
